// File: rtl/logic_gate_sweep_ctrl.sv
// Sweep controller for the 2-input gate unit: drives all four A/B vectors,
// waits for the outputs to settle, then checks the six gate results.
module logic_gate_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned REPEAT        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] y_in,
  output logic       a_out,
  output logic       b_out,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_mask,
  output logic [7:0] err_count
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned GATES = 6;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_SWEEP  = CNT_W'(REPEAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   settle_cnt, settle_d;
  logic [CNT_W-1:0]   sweep_cnt, sweep_d;
  logic               a_d, b_d, busy_d, done_d, pass_d;
  logic [1:0]         vec_d;
  logic [GATES-1:0]   mask_d;
  logic [7:0]         count_d;
  logic [GATES-1:0]   exp_c, mism_c;

  // Expected gate outputs for the operands currently applied, and the per-gate mismatch
  always_comb begin
    exp_c  = {a_out & b_out, ~(a_out & b_out), ~(a_out | b_out),
              a_out | b_out, ~(a_out ^ b_out), a_out ^ b_out};
    mism_c = y_in ^ exp_c;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    settle_d = settle_cnt;
    sweep_d  = sweep_cnt;
    a_d      = a_out;
    b_d      = b_out;
    vec_d    = vec_idx;
    busy_d   = busy;
    done_d   = 1'b0;
    pass_d   = pass;
    mask_d   = err_mask;
    count_d  = err_count;
    case (state)
      S_IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          mask_d  = '0;
          count_d = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          sweep_d = '0;
          busy_d  = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        a_d      = vec_idx[1];
        b_d      = vec_idx[0];
        settle_d = SETTLE_LOAD;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt == '0) state_d = S_SAMPLE;
        else                  settle_d = settle_cnt - CNT_W'(1);
      end
      S_SAMPLE: begin
        mask_d = err_mask | mism_c;
        if ((|mism_c) && (err_count != 8'hFF)) count_d = err_count + 8'd1;
        if ((vec_idx == 2'd3) && (sweep_cnt == LAST_SWEEP)) begin
          // Last sample: pass must include this sample's result
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (mask_d == '0);
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          vec_d = vec_idx + 2'd1;
          if (vec_idx == 2'd3) sweep_d = sweep_cnt + CNT_W'(1);
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      sweep_cnt  <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      vec_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_mask   <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_d;
      sweep_cnt  <= sweep_d;
      a_out      <= a_d;
      b_out      <= b_d;
      vec_idx    <= vec_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_mask   <= mask_d;
      err_count  <= count_d;
    end
  end

endmodule
